bullet_slot_scheduler: RTL and testbench

Sequences a bank of bullet position handler instances, one per bullet slot, so the player can have several shots in flight. It accepts fire requests, allocates a free slot, and drives that slot's reset, wait and update controls from the frame tick. It retires a slot when its bullet reaches the top or registers a hit. The block sits between the input/game-logic layer and the per-slot bullet position handlers; all per-slot handlers share `clk`.

---
 rtl/bullet_slot_scheduler.sv | 140 ++++++++++++++
 tb/tb_bullet_slot_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bullet_slot_scheduler.sv
// Bullet slot scheduler: allocates fire requests to free handler slots and
// sequences each slot's reset/wait/update controls from the frame tick.

module bullet_slot_fsm (
    input  logic clk,
    input  logic resetn,
    input  logic alloc,
    input  logic retire_req,
    input  logic update_tick,
    output logic slot_reset,
    output logic slot_wait,
    output logic slot_active,
    output logic slot_update
);
    typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, FLY = 2'd2} state_t;

    state_t state_q, state_d;
    logic   update_q, update_d;
    logic   retire;

    // Retire requests only count while flying; a stale reachtop in IDLE is ignored.
    assign retire = (state_q == FLY) && retire_req;

    always_comb begin
        state_d  = state_q;
        update_d = 1'b0;
        case (state_q)
            IDLE:    if (alloc) state_d = LAUNCH;
            LAUNCH:  state_d = FLY;
            FLY: begin
                if (retire) state_d = IDLE;
                update_d = update_tick && !retire;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            update_q <= update_d;
        end
    end

    assign slot_reset  = (state_q == IDLE);
    assign slot_wait   = (state_q == LAUNCH);
    assign slot_active = (state_q == LAUNCH) || (state_q == FLY);
    assign slot_update = update_q;
endmodule

module bullet_slot_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int COOLDOWN   = 8,
    parameter int UPDATE_DIV = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fire,
    input  logic                 frameTick,
    input  logic [NUM_SLOTS-1:0] reachtop,
    input  logic [NUM_SLOTS-1:0] hit,
    output logic [NUM_SLOTS-1:0] slotReset,
    output logic [NUM_SLOTS-1:0] slotWait,
    output logic [NUM_SLOTS-1:0] slotUpdate,
    output logic [NUM_SLOTS-1:0] slotActive,
    output logic                 cooldownBusy,
    output logic [7:0]           shotCount
);
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int DW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    logic [CW-1:0]        cooldown_q, cooldown_d;
    logic [DW-1:0]        div_cnt_q, div_cnt_d;
    logic [7:0]           shot_count_q, shot_count_d;
    logic                 update_tick;
    logic                 accept;
    logic                 found;
    logic [NUM_SLOTS-1:0] alloc;

    assign update_tick = frameTick && (div_cnt_q == DW'(UPDATE_DIV - 1));
    assign accept      = fire && (cooldown_q == '0) && (|slotReset);

    // Lowest-indexed IDLE slot wins; uses registered state so a slot retiring
    // this cycle is not reallocated until it has spent a cycle in IDLE.
    always_comb begin
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && slotReset[i]) begin
                alloc[i] = accept;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        cooldown_d   = cooldown_q;
        div_cnt_d    = div_cnt_q;
        shot_count_d = shot_count_q;
        if (accept) begin
            cooldown_d   = CW'(COOLDOWN);
            shot_count_d = shot_count_q + 8'd1;
        end else if (frameTick && cooldown_q != '0) begin
            cooldown_d = cooldown_q - CW'(1);
        end
        if (frameTick) div_cnt_d = update_tick ? '0 : div_cnt_q + DW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cooldown_q   <= '0;
            div_cnt_q    <= '0;
            shot_count_q <= '0;
        end else begin
            cooldown_q   <= cooldown_d;
            div_cnt_q    <= div_cnt_d;
            shot_count_q <= shot_count_d;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bullet_slot_fsm u_slot (
            .clk         (clk),
            .resetn      (resetn),
            .alloc       (alloc[i]),
            .retire_req  (reachtop[i] | hit[i]),
            .update_tick (update_tick),
            .slot_reset  (slotReset[i]),
            .slot_wait   (slotWait[i]),
            .slot_active (slotActive[i]),
            .slot_update (slotUpdate[i])
        );
    end

    assign cooldownBusy = (cooldown_q != '0);
    assign shotCount    = shot_count_q;
endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Random-stimulus bench for bullet_slot_scheduler against a slot-list reference model.

module tb_bullet_slot_scheduler;
    localparam int NS   = 4;
    localparam int CD   = 8;
    localparam int UDIV = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          fire = 1'b0;
    logic          frameTick = 1'b0;
    logic [NS-1:0] reachtop = '0;
    logic [NS-1:0] hit = '0;
    logic [NS-1:0] slotReset, slotWait, slotUpdate, slotActive;
    logic          cooldownBusy;
    logic [7:0]    shotCount;

    int n_tests = 0;
    int n_fail  = 0;

    // model: per-slot phase as text-like codes, counters as plain ints
    int m_phase [NS];   // 0 idle, 1 launching, 2 flying
    bit m_upd   [NS];
    int m_cd, m_div, m_shots, m_total_accepts;

    bullet_slot_scheduler #(.NUM_SLOTS(NS), .COOLDOWN(CD), .UPDATE_DIV(UDIV)) dut (
        .clk(clk), .resetn(resetn), .fire(fire), .frameTick(frameTick),
        .reachtop(reachtop), .hit(hit), .slotReset(slotReset), .slotWait(slotWait),
        .slotUpdate(slotUpdate), .slotActive(slotActive),
        .cooldownBusy(cooldownBusy), .shotCount(shotCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin m_phase[i] = 0; m_upd[i] = 0; end
        m_cd = 0; m_div = 0; m_shots = 0;
    endtask

    task automatic model_step();
        bit tick, ok;
        int pick;
        tick = frameTick && (m_div == UDIV - 1);
        pick = -1;
        for (int i = NS - 1; i >= 0; i--) if (m_phase[i] == 0) pick = i;
        ok = fire && (m_cd == 0) && (pick >= 0);
        for (int i = 0; i < NS; i++) begin
            bit leaving;
            leaving  = (m_phase[i] == 2) && (reachtop[i] || hit[i]);
            m_upd[i] = (m_phase[i] == 2) && tick && !leaving;
            if (m_phase[i] == 1) m_phase[i] = 2;
            else if (leaving)    m_phase[i] = 0;
        end
        if (ok) begin
            m_phase[pick] = 1;
            m_cd = CD;
            m_shots = (m_shots + 1) % 256;
            m_total_accepts++;
        end else if (frameTick && m_cd > 0) begin
            m_cd--;
        end
        if (frameTick) m_div = (m_div + 1) % UDIV;
    endtask

    task automatic check_all(input string where);
        logic [NS-1:0] e_rst, e_wait, e_act, e_upd;
        for (int i = 0; i < NS; i++) begin
            e_rst[i]  = (m_phase[i] == 0);
            e_wait[i] = (m_phase[i] == 1);
            e_act[i]  = (m_phase[i] != 0);
            e_upd[i]  = m_upd[i];
        end
        check({where, ".slotReset"},    32'(slotReset),    32'(e_rst));
        check({where, ".slotWait"},     32'(slotWait),     32'(e_wait));
        check({where, ".slotActive"},   32'(slotActive),   32'(e_act));
        check({where, ".slotUpdate"},   32'(slotUpdate),   32'(e_upd));
        check({where, ".cooldownBusy"}, 32'(cooldownBusy), 32'(m_cd != 0));
        check({where, ".shotCount"},    32'(shotCount),    32'(m_shots));
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            fire      = ($urandom_range(0, 2) == 0);
            frameTick = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NS; i++) begin
                reachtop[i] = ($urandom_range(0, 19) == 0);
                hit[i]      = ($urandom_range(0, 19) == 0);
            end
            @(posedge clk);
            model_step();
            #1 check_all("run");
        end
    endtask

    initial begin
        m_total_accepts = 0;
        model_reset();
        #2 check_all("por");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        // idle inputs: nothing may move
        repeat (4) begin
            @(posedge clk);
            model_step();
            #1 check_all("quiet");
        end
        run_cycles(3000);

        // asynchronous reset mid-flight, observed before any clock edge
        @(negedge clk);
        fire = 0; frameTick = 0; reachtop = '0; hit = '0;
        #2 resetn = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        run_cycles(9000);

        check("shotcount_wrapped", 32'(m_total_accepts > 256), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
